// File: rtl/tetris_pkg.sv
// Shared types, constants and the tetromino shape ROM for the falling-piece controller.
// Maps are 4x4, bit 15-(dy*4+dx), and every rotation is top-left normalized.
package tetris_pkg;

    localparam int BOARD_H = 16;

    typedef enum logic [2:0] {
        PC_I = 3'd0,
        PC_O = 3'd1,
        PC_T = 3'd2,
        PC_S = 3'd3,
        PC_Z = 3'd4,
        PC_J = 3'd5,
        PC_L = 3'd6
    } piece_t;

    typedef logic [2:0] ctrl_state_t;

    localparam ctrl_state_t ST_IDLE      = 3'd0;
    localparam ctrl_state_t ST_LOAD      = 3'd1;
    localparam ctrl_state_t ST_SPAWN     = 3'd2;
    localparam ctrl_state_t ST_FALL      = 3'd3;
    localparam ctrl_state_t ST_LOCK      = 3'd4;
    localparam ctrl_state_t ST_GAME_OVER = 3'd5;

    function automatic logic [15:0] piece_map(input piece_t kind, input logic [1:0] rot);
        logic [15:0] map;
        map = 16'h0000;
        case (kind)
            PC_I: map = rot[0] ? 16'h8888 : 16'hF000;
            PC_O: map = 16'hCC00;
            PC_S: map = rot[0] ? 16'h8C40 : 16'h6C00;
            PC_Z: map = rot[0] ? 16'h4C80 : 16'hC600;
            PC_T: begin
                case (rot)
                    2'd0:    map = 16'h4E00;
                    2'd1:    map = 16'h8C80;
                    2'd2:    map = 16'hE400;
                    default: map = 16'h4C40;
                endcase
            end
            PC_J: begin
                case (rot)
                    2'd0:    map = 16'h8E00;
                    2'd1:    map = 16'hC880;
                    2'd2:    map = 16'hE200;
                    default: map = 16'h44C0;
                endcase
            end
            PC_L: begin
                case (rot)
                    2'd0:    map = 16'h2E00;
                    2'd1:    map = 16'h88C0;
                    2'd2:    map = 16'hE800;
                    default: map = 16'hC440;
                endcase
            end
            default: map = 16'h0000;
        endcase
        return map;
    endfunction

    // The random source is 3 bits wide; the unused code folds onto the I piece.
    function automatic piece_t to_piece(input logic [2:0] raw);
        piece_t kind;
        if (raw == 3'd7) begin
            kind = PC_I;
        end else begin
            kind = piece_t'(raw);
        end
        return kind;
    endfunction

endpackage

// File: rtl/piece_fits.sv
// Combinational collision check of a candidate 4x4 map placed at (x, y) against
// the playfield walls, floor and settled cells. 5-bit coordinates never wrap.
module piece_fits
    import tetris_pkg::*;
#(
    parameter int PLAY_W = 10
) (
    input  logic [15:0]       map,
    input  logic [4:0]        x,
    input  logic [4:0]        y,
    input  logic [15:0][15:0] board_occ,
    output logic              fits
);

    logic [4:0] cx_s;
    logic [4:0] cy_s;

    // Scan all 16 map cells; any set cell out of bounds or on a settled cell fails.
    always_comb begin
        fits = 1'b1;
        cx_s = 5'd0;
        cy_s = 5'd0;
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                cx_s = x + 5'(dx);
                cy_s = y + 5'(dy);
                if (map[15 - (dy * 4 + dx)]) begin
                    if ((cx_s >= 5'(PLAY_W)) || (cy_s > 5'(BOARD_H - 1))) begin
                        fits = 1'b0;
                    end else if (board_occ[cy_s[3:0]][cx_s[3:0]]) begin
                        fits = 1'b0;
                    end else begin
                        fits = fits;
                    end
                end else begin
                    fits = fits;
                end
            end
        end
    end

endmodule

// File: rtl/piece_ctrl.sv
// Active-tetromino sequencer: spawn, player moves, gravity, lock handshake with
// the board-merge logic, and game-over detection. All outputs are registered.
module piece_ctrl
    import tetris_pkg::*;
#(
    parameter int PLAY_W  = 10,
    parameter int SPAWN_X = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mv_left,
    input  logic              mv_right,
    input  logic              rot,
    input  logic              grav_tick,
    input  logic [2:0]        rand_type,
    input  logic [15:0][15:0] board_occ,
    input  logic              lock_ack,
    output logic [15:0]       curr_piece_map,
    output logic [3:0]        curr_x,
    output logic [3:0]        curr_y,
    output logic [15:0]       next_piece_map,
    output logic              lock_req,
    output logic [15:0]       lock_map,
    output logic [3:0]        lock_x,
    output logic [3:0]        lock_y,
    output logic              game_over
);

    localparam logic [3:0] SPAWN_X_C = 4'(SPAWN_X);

    ctrl_state_t state_r, state_s;
    piece_t      type_r, type_s, next_type_r, next_type_s, rand_piece_s;
    logic [1:0]  rot_r, rot_s;
    logic [3:0]  x_r, x_s, y_r, y_s;
    logic [15:0] cand_map_s;
    logic [4:0]  cand_x_s, cand_y_s;
    logic        fits_s;
    logic        show_s;

    logic [15:0] curr_map_r, next_map_r, lock_map_r;
    logic [3:0]  lock_x_r, lock_y_r;
    logic        lock_req_r, game_over_r;

    assign rand_piece_s = to_piece(rand_type);

    // Select the one placement the fit checker judges this cycle.
    always_comb begin
        cand_map_s = piece_map(type_r, rot_r);
        cand_x_s   = {1'b0, x_r};
        cand_y_s   = {1'b0, y_r};
        case (state_r)
            ST_SPAWN: begin
                cand_map_s = piece_map(next_type_r, 2'd0);
                cand_x_s   = {1'b0, SPAWN_X_C};
                cand_y_s   = 5'd0;
            end
            ST_FALL: begin
                if (grav_tick) begin
                    cand_y_s = {1'b0, y_r} + 5'd1;
                end else if (rot) begin
                    cand_map_s = piece_map(type_r, rot_r + 2'd1);
                end else if (mv_left) begin
                    cand_x_s = {1'b0, x_r} - 5'd1;
                end else if (mv_right) begin
                    cand_x_s = {1'b0, x_r} + 5'd1;
                end else begin
                    cand_y_s = {1'b0, y_r};
                end
            end
            default: cand_x_s = {1'b0, x_r};
        endcase
    end

    piece_fits #(.PLAY_W(PLAY_W)) u_fits (
        .map       (cand_map_s),
        .x         (cand_x_s),
        .y         (cand_y_s),
        .board_occ (board_occ),
        .fits      (fits_s)
    );

    // Next-state and next piece-position logic.
    always_comb begin
        state_s     = state_r;
        type_s      = type_r;
        rot_s       = rot_r;
        x_s         = x_r;
        y_s         = y_r;
        next_type_s = next_type_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_IDLE;
            end
            ST_LOAD: begin
                next_type_s = rand_piece_s;
                state_s     = ST_SPAWN;
            end
            ST_SPAWN: begin
                type_s      = next_type_r;
                rot_s       = 2'd0;
                x_s         = SPAWN_X_C;
                y_s         = 4'd0;
                next_type_s = rand_piece_s;
                if (fits_s) state_s = ST_FALL;
                else        state_s = ST_GAME_OVER;
            end
            ST_FALL: begin
                if (grav_tick) begin
                    if ((y_r != 4'd15) && fits_s) y_s = cand_y_s[3:0];
                    else                          state_s = ST_LOCK;
                end else if (rot) begin
                    if (fits_s) rot_s = rot_r + 2'd1;
                    else        rot_s = rot_r;
                end else if (mv_left) begin
                    if ((x_r != 4'd0) && fits_s) x_s = cand_x_s[3:0];
                    else                         x_s = x_r;
                end else if (mv_right) begin
                    if (fits_s) x_s = cand_x_s[3:0];
                    else        x_s = x_r;
                end else begin
                    state_s = ST_FALL;
                end
            end
            ST_LOCK: begin
                if (lock_ack) state_s = ST_SPAWN;
                else          state_s = ST_LOCK;
            end
            ST_GAME_OVER: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_GAME_OVER;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    assign show_s = (state_s == ST_FALL) || (state_s == ST_LOCK) || (state_s == ST_GAME_OVER);

    // State, piece registers and registered outputs, all derived from next-state values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            type_r      <= PC_I;
            rot_r       <= 2'd0;
            x_r         <= 4'd0;
            y_r         <= 4'd0;
            next_type_r <= PC_I;
            curr_map_r  <= 16'h0000;
            next_map_r  <= 16'h0000;
            lock_req_r  <= 1'b0;
            lock_map_r  <= 16'h0000;
            lock_x_r    <= 4'd0;
            lock_y_r    <= 4'd0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            type_r      <= type_s;
            rot_r       <= rot_s;
            x_r         <= x_s;
            y_r         <= y_s;
            next_type_r <= next_type_s;
            curr_map_r  <= show_s ? piece_map(type_s, rot_s) : 16'h0000;
            next_map_r  <= (state_s == ST_IDLE) ? 16'h0000 : piece_map(next_type_s, 2'd0);
            lock_req_r  <= (state_s == ST_LOCK);
            lock_map_r  <= (state_s == ST_LOCK) ? piece_map(type_s, rot_s) : 16'h0000;
            lock_x_r    <= (state_s == ST_LOCK) ? x_s : 4'd0;
            lock_y_r    <= (state_s == ST_LOCK) ? y_s : 4'd0;
            game_over_r <= (state_s == ST_GAME_OVER);
        end
    end

    assign curr_piece_map = curr_map_r;
    assign curr_x         = x_r;
    assign curr_y         = y_r;
    assign next_piece_map = next_map_r;
    assign lock_req       = lock_req_r;
    assign lock_map       = lock_map_r;
    assign lock_x         = lock_x_r;
    assign lock_y         = lock_y_r;
    assign game_over      = game_over_r;

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl: spawn, gravity/lock handshake, walls, collision,
// priority, spawn failure and asynchronous reset, with hand-computed expectations.
module tb_piece_ctrl;
    import tetris_pkg::*;

    logic              clk;
    logic              reset_n;
    logic              start, mv_left, mv_right, rot, grav_tick, lock_ack;
    logic [2:0]        rand_type;
    logic [15:0][15:0] board_occ;
    logic [15:0]       curr_piece_map, next_piece_map, lock_map;
    logic [3:0]        curr_x, curr_y, lock_x, lock_y;
    logic              lock_req, game_over;

    int n_checks = 0;
    int n_bad    = 0;

    piece_ctrl #(.PLAY_W(10), .SPAWN_X(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .mv_left        (mv_left),
        .mv_right       (mv_right),
        .rot            (rot),
        .grav_tick      (grav_tick),
        .rand_type      (rand_type),
        .board_occ      (board_occ),
        .lock_ack       (lock_ack),
        .curr_piece_map (curr_piece_map),
        .curr_x         (curr_x),
        .curr_y         (curr_y),
        .next_piece_map (next_piece_map),
        .lock_req       (lock_req),
        .lock_map       (lock_map),
        .lock_x         (lock_x),
        .lock_y         (lock_y),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1ns after the edge; pulses are cleared.
    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0; mv_left = 1'b0; mv_right = 1'b0;
        rot = 1'b0; grav_tick = 1'b0; lock_ack = 1'b0;
    endtask

    task automatic drop_to_lock();
        int n;
        n = 0;
        while (lock_req !== 1'b1 && n < 20) begin
            grav_tick = 1'b1;
            tick();
            n++;
        end
        check_val("drop_lock", {15'd0, lock_req}, 16'h0001);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; mv_left = 1'b0; mv_right = 1'b0;
        rot = 1'b0; grav_tick = 1'b0; lock_ack = 1'b0; rand_type = 3'd0;
        board_occ = '0;
        #12;
        check_val("rst_curr", curr_piece_map, 16'h0000);
        check_val("rst_next", next_piece_map, 16'h0000);
        check_val("rst_lock", {15'd0, lock_req}, 16'h0000);
        check_val("rst_go",   {15'd0, game_over}, 16'h0000);
        reset_n = 1'b1;

        // Start: O spawns, T queued
        start = 1'b1; rand_type = 3'd1;
        tick();
        tick();
        rand_type = 3'd2;
        tick();
        check_val("spawn_map",  curr_piece_map, 16'hCC00);
        check_val("spawn_x",    {12'd0, curr_x}, 16'd4);
        check_val("spawn_y",    {12'd0, curr_y}, 16'd0);
        check_val("spawn_next", next_piece_map, 16'h4E00);
        check_val("spawn_go",   {15'd0, game_over}, 16'h0000);

        // Gravity down to the floor and the lock handshake
        for (int i = 0; i < 14; i++) begin
            grav_tick = 1'b1;
            tick();
        end
        check_val("grav_y14", {12'd0, curr_y}, 16'd14);
        grav_tick = 1'b1;
        tick();
        check_val("lock_req",  {15'd0, lock_req}, 16'h0001);
        check_val("lock_map",  lock_map, 16'hCC00);
        check_val("lock_x",    {12'd0, lock_x}, 16'd4);
        check_val("lock_y",    {12'd0, lock_y}, 16'd14);
        for (int i = 0; i < 5; i++) begin
            grav_tick = (i == 1); mv_left = (i == 2); rot = (i == 3);
            tick();
        end
        check_val("hold_req",  {15'd0, lock_req}, 16'h0001);
        check_val("hold_map",  lock_map, 16'hCC00);
        check_val("hold_y",    {12'd0, lock_y}, 16'd14);
        check_val("hold_curr", curr_piece_map, 16'hCC00);
        rand_type = 3'd0;
        lock_ack = 1'b1;
        tick();
        check_val("ack_drop", {15'd0, lock_req}, 16'h0000);
        tick();
        check_val("t_map",  curr_piece_map, 16'h4E00);
        check_val("t_x",    {12'd0, curr_x}, 16'd4);
        check_val("t_y",    {12'd0, curr_y}, 16'd0);
        check_val("t_next", next_piece_map, 16'hF000);

        // Gravity wins over a simultaneous move
        grav_tick = 1'b1; mv_left = 1'b1;
        tick();
        check_val("prio_y", {12'd0, curr_y}, 16'd1);
        check_val("prio_x", {12'd0, curr_x}, 16'd4);
        rot = 1'b1;
        tick();
        check_val("rot_t", curr_piece_map, 16'h8C80);

        // Lock T, spawn I, test the walls
        drop_to_lock();
        rand_type = 3'd3; lock_ack = 1'b1;
        tick();
        tick();
        check_val("i_map", curr_piece_map, 16'hF000);
        mv_right = 1'b1; tick();
        mv_right = 1'b1; tick();
        check_val("i_x6", {12'd0, curr_x}, 16'd6);
        mv_right = 1'b1; tick();
        check_val("wall_r", {12'd0, curr_x}, 16'd6);
        for (int i = 0; i < 6; i++) begin
            mv_left = 1'b1;
            tick();
        end
        check_val("i_x0", {12'd0, curr_x}, 16'd0);
        mv_left = 1'b1; tick();
        check_val("wall_l", {12'd0, curr_x}, 16'd0);

        // Lock I, run S down, then an O with the 7->I next piece
        drop_to_lock();
        rand_type = 3'd1; lock_ack = 1'b1;
        tick();
        tick();
        check_val("s_map", curr_piece_map, 16'h6C00);
        drop_to_lock();
        rand_type = 3'd7; lock_ack = 1'b1;
        tick();
        tick();
        check_val("o_map",   curr_piece_map, 16'hCC00);
        check_val("r7_next", next_piece_map, 16'hF000);

        // Settled cell below the O
        board_occ[5][4] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            grav_tick = 1'b1;
            tick();
        end
        check_val("coll_y3", {12'd0, curr_y}, 16'd3);
        grav_tick = 1'b1;
        tick();
        check_val("coll_req", {15'd0, lock_req}, 16'h0001);
        check_val("coll_ly",  {12'd0, lock_y}, 16'd3);

        // Blocked spawn column: the I cannot enter
        board_occ = '0;
        board_occ[0][4] = 1'b1;
        board_occ[0][5] = 1'b1;
        lock_ack = 1'b1;
        tick();
        tick();
        check_val("go_flag", {15'd0, game_over}, 16'h0001);
        check_val("go_map",  curr_piece_map, 16'hF000);
        mv_left = 1'b1; tick();
        check_val("go_nomove", {12'd0, curr_x}, 16'd4);

        // Restart from game over
        board_occ = '0;
        start = 1'b1; rand_type = 3'd2;
        tick();
        check_val("restart_map", curr_piece_map, 16'h0000);
        check_val("restart_go",  {15'd0, game_over}, 16'h0000);
        tick();
        tick();
        check_val("restart_t", curr_piece_map, 16'h4E00);
        grav_tick = 1'b1;
        tick();
        check_val("restart_y1", {12'd0, curr_y}, 16'd1);

        // Asynchronous reset in the middle of a cycle
        #3;
        reset_n = 1'b0;
        #1;
        check_val("arst_map",  curr_piece_map, 16'h0000);
        check_val("arst_y",    {12'd0, curr_y}, 16'd0);
        check_val("arst_next", next_piece_map, 16'h0000);
        check_val("arst_req",  {15'd0, lock_req}, 16'h0000);
        #20;
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
